branch_pred_table: RTL and testbench
====================================

// Module: branch_pred_table
// PURPOSE
//  Pattern history table holding 2^IDX_W 2-bit saturating counters, indexed by PC bits.
//  Read side serves fetch: registered taken/not-taken prediction for LookupPC.
//  Write side applies resolved-branch outcomes from execute (SNT/NT/T/ST counter rules).
//  Keeps lookup and misprediction statistics for the BTB performance counters.
// PARAMETERS
//  IDX_W   4   index width; table depth = 2^IDX_W entries
//  PC_LSB  2   lowest PC bit used in index; index = PC[PC_LSB+IDX_W-1:PC_LSB]
//  CNT_W   16  width of each statistics counter
// PORTS
//  Clk            in   1      clock; all state changes on falling edge
//  Rst            in   1      asynchronous, active-low reset
//  LookupValid    in   1      fetch requests a prediction this cycle
//  LookupPC       in   32     fetch PC
//  PredValid      out  1      prediction below is valid (1 cycle after LookupValid)
//  PredTaken      out  1      predicted direction (MSB of counter)
//  PredState      out  2      full counter value read
//  UpdValid       in   1      resolved branch update this cycle
//  UpdPC          in   32     PC of resolved branch
//  UpdTaken       in   1      actual outcome
//  UpdPredTaken   in   1      direction that was predicted for this branch
//  LookupCnt      out  CNT_W  number of accepted lookups, saturating
//  MispredCnt     out  CNT_W  number of updates with UpdTaken != UpdPredTaken, saturating
// BEHAVIOUR
//  Reset (Rst=0, async): every table entry = 2'b00 (SNT); PredValid=0, PredTaken=0,
//   PredState=2'b00, LookupCnt=0, MispredCnt=0. Held while Rst=0; lookups/updates ignored.
//  Counter rule on update (cur -> next): taken: 00->01, 01->10, 10->11, 11->11;
//   not taken: 00->00, 01->00, 10->01, 11->10. Only the indexed entry changes.
//  Lookup latency 1 edge: on falling edge with LookupValid=1, PredState <= entry[idx(LookupPC)],
//   PredTaken <= that value's bit 1, PredValid <= 1. LookupValid=0 -> PredValid <= 0,
//   PredState/PredTaken hold last value.
//  Update latency 1 edge: entry written on the falling edge where UpdValid=1.
//  Same-edge conflict: LookupValid & UpdValid & idx equal -> PredState returns the NEW
//   (post-update) counter value (write-first bypass).
//  Different indices same edge: both operations proceed independently.
//  Aliasing: PCs with equal index bits share one counter; no tag check.
//  LookupCnt += 1 per edge with LookupValid=1; MispredCnt += 1 per edge with UpdValid=1 and
//   UpdTaken != UpdPredTaken; both stick at 2^CNT_W-1, never wrap.
//  Rst asserted mid-operation: table and stats cleared immediately; an update or lookup
//   in flight is dropped; first valid prediction after release is SNT.
//  No back-pressure: one lookup and one update accepted every cycle.
// TESTING
//  1 Reset, LookupValid with PC 0x40 -> next edge PredValid=1, PredState=00, PredTaken=0.
//  2 Three updates PC 0x40 taken, lookup after each -> PredState 01,10,11; PredTaken flips
//    to 1 after the second; fourth taken update keeps 11; two not-taken -> 10 then 01.
//  3 Same edge: update PC 0x80 taken (entry 10) + lookup PC 0x80 -> PredState=11, PredTaken=1.
//  4 Alias: IDX_W=4, train PC 0x04 to 11, lookup PC 0x44 -> PredState=11; PC 0x08 -> 00.
//  5 Updates with UpdTaken=1, UpdPredTaken=0 x5 and matching x3 -> MispredCnt=5; force
//    CNT_W=4, 20 mispredicts -> MispredCnt=15 held; LookupCnt likewise saturates.
//  6 Train several entries, pulse Rst low between edges -> all outputs 0 asynchronously;
//    after release every lookup returns 00, stats restart from 0.

Source files
------------

// File: rtl/branch_pred_table.sv
// ----------------------------------------------------------------------------
// branch_pred_table
//   Pattern history table of 2^IDX_W two-bit saturating counters indexed by
//   PC[PC_LSB+IDX_W-1:PC_LSB]. There is no tag check, so PCs with equal index
//   bits share a counter.
//
//   Fetch side: a registered prediction for LookupPC appears one edge after
//   LookupValid is seen.
//   Execute side: resolved branch outcomes train the indexed counter.
//   Statistics: saturating counts of accepted lookups and of mispredicted
//   updates.
//
//   All state changes on the FALLING edge of Clk. Rst is asynchronous and
//   active-low.
//
// Ports
//   Clk           in   1      clock (falling-edge active)
//   Rst           in   1      asynchronous active-low reset
//   LookupValid   in   1      fetch requests a prediction
//   LookupPC      in   32     fetch PC
//   PredValid     out  1      prediction valid (one edge after LookupValid)
//   PredTaken     out  1      predicted direction (counter MSB)
//   PredState     out  2      full counter value read
//   UpdValid      in   1      resolved branch update
//   UpdPC         in   32     PC of the resolved branch
//   UpdTaken      in   1      actual outcome
//   UpdPredTaken  in   1      direction that was predicted for this branch
//   LookupCnt     out  CNT_W  accepted lookups, saturating
//   MispredCnt    out  CNT_W  updates with UpdTaken != UpdPredTaken, saturating
// ----------------------------------------------------------------------------
module branch_pred_table #(
    parameter int IDX_W  = 4,
    parameter int PC_LSB = 2,
    parameter int CNT_W  = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             LookupValid,
    input  logic [31:0]      LookupPC,
    output logic             PredValid,
    output logic             PredTaken,
    output logic [1:0]       PredState,
    input  logic             UpdValid,
    input  logic [31:0]      UpdPC,
    input  logic             UpdTaken,
    input  logic             UpdPredTaken,
    output logic [CNT_W-1:0] LookupCnt,
    output logic [CNT_W-1:0] MispredCnt
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Two-bit counter encodings: strongly/weakly not-taken, weakly/strongly taken.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    logic [1:0]       table_q [DEPTH];
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_cur;
    logic [1:0]       upd_next;
    logic [1:0]       lookup_val;
    logic             mispredict;

    assign lookup_idx = LookupPC[PC_LSB+IDX_W-1:PC_LSB];
    assign upd_idx    = UpdPC[PC_LSB+IDX_W-1:PC_LSB];
    assign upd_cur    = table_q[upd_idx];
    assign mispredict = UpdValid && (UpdTaken != UpdPredTaken);

    // Only the index bits of the PCs select an entry; the rest are ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{LookupPC, UpdPC};

    // Saturating two-bit counter step.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        upd_next = upd_cur;
        case (upd_cur)
            SNT:     upd_next = UpdTaken ? WNT : SNT;
            WNT:     upd_next = UpdTaken ? WT  : SNT;
            WT:      upd_next = UpdTaken ? ST  : WNT;
            ST:      upd_next = UpdTaken ? ST  : WT;
            default: upd_next = upd_cur;
        endcase
    end

    // Write-first bypass: a lookup that hits the entry being updated on the
    // same edge sees the post-update value.
    always_comb begin
        lookup_val = table_q[lookup_idx];
        if (UpdValid && (upd_idx == lookup_idx)) begin
            lookup_val = upd_next;
        end
    end

    // NOTE: the table is an array of flops, not a RAM macro, so it can and
    // must be cleared by the asynchronous reset like any other state.
    always_ff @(negedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= SNT;
            end
        end else if (UpdValid) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            table_q[upd_idx] <= upd_next;
        end
    end

    // Registered prediction; PredState/PredTaken hold when no lookup.
    always_ff @(negedge Clk or negedge Rst) begin
        if (!Rst) begin
            PredValid <= 1'b0;
            PredTaken <= 1'b0;
            PredState <= SNT;
        end else begin
            PredValid <= LookupValid;
            if (LookupValid) begin
                PredState <= lookup_val;
                PredTaken <= lookup_val[1];
            end
        end
    end

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(negedge Clk or negedge Rst) begin
        if (!Rst) begin
            LookupCnt  <= '0;
            MispredCnt <= '0;
        end else begin
            if (LookupValid && (LookupCnt != CNT_MAX)) begin
                LookupCnt <= LookupCnt + 1'b1;
            end
            if (mispredict && (MispredCnt != CNT_MAX)) begin
                MispredCnt <= MispredCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_table.sv
// ----------------------------------------------------------------------------
// tb_branch_pred_table
//   Directed bench for branch_pred_table. Two instances share all inputs: one
//   with default 16-bit statistics and one with 4-bit statistics so saturation
//   is reachable. Expected predictions come from a reference table of counters
//   and are queued when a lookup is driven, then popped when PredValid shows.
//   The DUT is falling-edge clocked; inputs change and outputs are sampled on
//   the rising edge.
// ----------------------------------------------------------------------------
module tb_branch_pred_table;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred_taken = 1'b0;

    logic        pred_valid, pred_taken;
    logic [1:0]  pred_state;
    logic [15:0] lookup_cnt, mispred_cnt;

    logic        s_pred_valid, s_pred_taken;
    logic [1:0]  s_pred_state;
    logic [3:0]  s_lookup_cnt, s_mispred_cnt;

    int errors = 0;
    int checks = 0;

    logic [1:0] model [16];
    int         n_lookup = 0;
    int         n_mispred = 0;
    logic [1:0] exp_q [$];
    logic [1:0] last_state = 2'b00;

    always #5 clk = ~clk;

    branch_pred_table dut (
        .Clk(clk), .Rst(rst),
        .LookupValid(lookup_valid), .LookupPC(lookup_pc),
        .PredValid(pred_valid), .PredTaken(pred_taken), .PredState(pred_state),
        .UpdValid(upd_valid), .UpdPC(upd_pc), .UpdTaken(upd_taken),
        .UpdPredTaken(upd_pred_taken),
        .LookupCnt(lookup_cnt), .MispredCnt(mispred_cnt)
    );

    branch_pred_table #(.CNT_W(4)) dut_s (
        .Clk(clk), .Rst(rst),
        .LookupValid(lookup_valid), .LookupPC(lookup_pc),
        .PredValid(s_pred_valid), .PredTaken(s_pred_taken), .PredState(s_pred_state),
        .UpdValid(upd_valid), .UpdPC(upd_pc), .UpdTaken(upd_taken),
        .UpdPredTaken(upd_pred_taken),
        .LookupCnt(s_lookup_cnt), .MispredCnt(s_mispred_cnt)
    );

    // Watchdog: every wait is clock-bounded, this only catches a dead clock.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference counter rules written out as a table.
    function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
        logic [1:0] n;
        case ({t, c})
            3'b1_00: n = 2'b01;
            3'b1_01: n = 2'b10;
            3'b1_10: n = 2'b11;
            3'b1_11: n = 2'b11;
            3'b0_00: n = 2'b00;
            3'b0_01: n = 2'b00;
            3'b0_10: n = 2'b01;
            default: n = 2'b10;
        endcase
        return n;
    endfunction

    function automatic int pidx(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_lookup_cnt"},    32'(lookup_cnt),    32'(sat(n_lookup, 65535)));
        check({tag, "_mispred_cnt"},   32'(mispred_cnt),   32'(sat(n_mispred, 65535)));
        check({tag, "_lookup_cnt4"},   32'(s_lookup_cnt),  32'(sat(n_lookup, 15)));
        check({tag, "_mispred_cnt4"},  32'(s_mispred_cnt), 32'(sat(n_mispred, 15)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pred_valid"},  32'(pred_valid),    32'd0);
        check({tag, "_pred_taken"},  32'(pred_taken),    32'd0);
        check({tag, "_pred_state"},  32'(pred_state),    32'd0);
        check({tag, "_lookup_cnt"},  32'(lookup_cnt),    32'd0);
        check({tag, "_mispred_cnt"}, 32'(mispred_cnt),   32'd0);
        check({tag, "_s_valid"},     32'(s_pred_valid),  32'd0);
        check({tag, "_s_lookup"},    32'(s_lookup_cnt),  32'd0);
        check({tag, "_s_mispred"},   32'(s_mispred_cnt), 32'd0);
    endtask

    // One falling edge with the given inputs; called at a rising edge.
    task automatic cycle(input logic lv, input logic [31:0] lpc,
                         input logic uv, input logic [31:0] upc,
                         input logic ut, input logic upt);
        logic [1:0] e;
        logic       exp_valid;
        lookup_valid   = lv;
        lookup_pc      = lpc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_pred_taken = upt;
        // Update applied to the model first: a same-index lookup sees new value.
        if (uv) begin
            model[pidx(upc)] = next_ctr(model[pidx(upc)], ut);
            if (ut != upt) n_mispred++;
        end
        if (lv) begin
            exp_q.push_back(model[pidx(lpc)]);
            n_lookup++;
        end
        exp_valid = lv;
        @(negedge clk);
        @(posedge clk);
        check("pred_valid", 32'(pred_valid), 32'(exp_valid));
        if (exp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_state = e;
            check("pred_state", 32'(pred_state), 32'(e));
            check("pred_taken", 32'(pred_taken), 32'(e[1]));
        end else if (!exp_valid) begin
            check("pred_hold", 32'(pred_state), 32'(last_state));
        end
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        cycle(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic pt);
        cycle(1'b0, 32'h0, 1'b1, pc, t, pt);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 2'b00;
        n_lookup   = 0;
        n_mispred  = 0;
        last_state = 2'b00;
        exp_q.delete();
    endtask

    initial begin
        clear_model();

        // Reset state
        repeat (2) @(posedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // 1: first lookup after reset returns SNT
        lookup(32'h40);
        idle();

        // 2: training sequence on PC 0x40
        update(32'h40, 1'b1, 1'b1);
        lookup(32'h40);
        update(32'h40, 1'b1, 1'b1);
        lookup(32'h40);
        update(32'h40, 1'b1, 1'b1);
        lookup(32'h40);
        update(32'h40, 1'b1, 1'b1);
        lookup(32'h40);
        update(32'h40, 1'b0, 1'b0);
        lookup(32'h40);
        update(32'h40, 1'b0, 1'b0);
        lookup(32'h40);

        // 3: same-edge update and lookup (0x80 aliases 0x40, entry now 01)
        update(32'h80, 1'b1, 1'b1);
        cycle(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b1);
        idle();

        // 4: aliasing, 0x04 and 0x44 share index 1; 0x08 is index 2
        update(32'h04, 1'b1, 1'b1);
        update(32'h04, 1'b1, 1'b1);
        update(32'h04, 1'b1, 1'b1);
        lookup(32'h44);
        lookup(32'h08);
        // Different indices on the same edge proceed independently
        cycle(1'b1, 32'h08, 1'b1, 32'h04, 1'b0, 1'b0);
        lookup(32'h04);
        check_stats("pre_mispred");

        // 5: mispredict counting and saturation
        repeat (5) update(32'h0C, 1'b1, 1'b0);
        repeat (3) update(32'h0C, 1'b1, 1'b1);
        check_stats("mispred5");
        repeat (15) cycle(1'b1, 32'h10, 1'b1, 32'h0C, 1'b0, 1'b1);
        idle();
        check_stats("saturate");

        // 6: asynchronous reset mid-operation
        update(32'h10, 1'b1, 1'b1);
        update(32'h10, 1'b1, 1'b1);
        lookup(32'h10);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        // Activity while held in reset is ignored
        lookup_valid   = 1'b1;
        lookup_pc      = 32'h10;
        upd_valid      = 1'b1;
        upd_pc         = 32'h10;
        upd_taken      = 1'b0;
        upd_pred_taken = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("held_rst");
        @(posedge clk);
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
        rst          = 1'b1;
        clear_model();

        lookup(32'h04);
        lookup(32'h0C);
        lookup(32'h10);
        lookup(32'h40);
        idle();
        check_stats("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
